clk_divider_bank: RTL and testbench

Multi-channel programmable clock divider: the parametrised successor to the single-output divider. It generates CHANNELS independent divided outputs from one system clock. Each channel has its own divisor, output mode (50 % toggle or one-cycle strobe) and enable, plus a per-period tick. Divisor and mode changes are double-buffered and applied only at a period boundary, so outputs never glitch or produce runt periods. It sits between the board clock and the counter/gating logic of the frequency counter, where it supplies gate-time and display-refresh timebases.

---
 rtl/clk_divider_bank_if.sv | 36 +++
 rtl/clk_divider_bank.sv | 98 +++++++++
 tb/tb_clk_divider_bank.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/clk_divider_bank_if.sv
// Control/status bundle for clk_divider_bank: per-channel divisor, mode, load and enable
// inputs plus the divided outputs, tick and pending flags.
interface clk_divider_bank_if #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 32
);

  logic [CHANNELS*CNT_WIDTH-1:0] div;
  logic [CHANNELS-1:0]           mode;
  logic [CHANNELS-1:0]           load;
  logic [CHANNELS-1:0]           en;
  logic [CHANNELS-1:0]           clk_out;
  logic [CHANNELS-1:0]           tick;
  logic [CHANNELS-1:0]           pending;

  modport master (
    output div,
    output mode,
    output load,
    output en,
    input  clk_out,
    input  tick,
    input  pending
  );

  modport slave (
    input  div,
    input  mode,
    input  load,
    input  en,
    output clk_out,
    output tick,
    output pending
  );

endinterface

// File: rtl/clk_divider_bank.sv
// Bank of independent programmable clock dividers (toggle or strobe output) with
// double-buffered divisor/mode updates applied only at a period boundary.
module clk_divider_bank #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  clk_divider_bank_if.slave bus
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] act_div_q, act_div_d;
    logic                 act_mode_q, act_mode_d;
    logic [CNT_WIDTH-1:0] shd_div_q, shd_div_d;
    logic                 shd_mode_q, shd_mode_d;
    logic                 pending_q, pending_d;
    logic                 clk_out_q, clk_out_d;
    logic                 tick_q, tick_d;

    logic [CNT_WIDTH-1:0] in_div;
    logic                 in_mode;
    logic                 in_load;
    logic                 in_en;
    logic                 wrap;
    logic [CNT_WIDTH-1:0] next_div;
    logic                 next_mode;

    assign in_div  = bus.div[c*CNT_WIDTH +: CNT_WIDTH];
    assign in_mode = bus.mode[c];
    assign in_load = bus.load[c];
    assign in_en   = bus.en[c];

    // Equality is sufficient: act_div only changes on the wrap edge, so cnt never passes it.
    assign wrap = in_en && (cnt_q == act_div_q);

    // A load landing on the wrap edge bypasses the stale shadow and is applied directly.
    assign next_div  = in_load ? in_div  : shd_div_q;
    assign next_mode = in_load ? in_mode : shd_mode_q;

    always_comb begin
      cnt_d      = cnt_q;
      act_div_d  = act_div_q;
      act_mode_d = act_mode_q;
      shd_div_d  = shd_div_q;
      shd_mode_d = shd_mode_q;
      pending_d  = pending_q;
      clk_out_d  = clk_out_q;
      tick_d     = 1'b0;

      if (in_load) begin
        shd_div_d  = in_div;
        shd_mode_d = in_mode;
        pending_d  = 1'b1;
      end

      if (wrap) begin
        cnt_d      = '0;
        act_div_d  = next_div;
        act_mode_d = next_mode;
        pending_d  = 1'b0;
        tick_d     = 1'b1;
        clk_out_d  = next_mode ? 1'b1 : ~clk_out_q;
      end else if (in_en) begin
        cnt_d     = cnt_q + CNT_WIDTH'(1);
        clk_out_d = act_mode_q ? 1'b0 : clk_out_q;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q      <= '0;
        act_div_q  <= '0;
        act_mode_q <= 1'b0;
        shd_div_q  <= '0;
        shd_mode_q <= 1'b0;
        pending_q  <= 1'b0;
        clk_out_q  <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        act_div_q  <= act_div_d;
        act_mode_q <= act_mode_d;
        shd_div_q  <= shd_div_d;
        shd_mode_q <= shd_mode_d;
        pending_q  <= pending_d;
        clk_out_q  <= clk_out_d;
        tick_q     <= tick_d;
      end
    end

    assign bus.clk_out[c] = clk_out_q;
    assign bus.tick[c]    = tick_q;
    assign bus.pending[c] = pending_q;
  end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed bench for clk_divider_bank: per-cycle vector table plus hand sequences for
// enable freeze, D=0, asynchronous reset and multi-channel independence.
module tb_clk_divider_bank;

  localparam int unsigned CHANNELS  = 4;
  localparam int unsigned CNT_WIDTH = 32;

  logic clk;
  logic reset;

  clk_divider_bank_if #(.CHANNELS(CHANNELS), .CNT_WIDTH(CNT_WIDTH)) bus ();

  clk_divider_bank #(
    .CHANNELS (CHANNELS),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          rst_first;
    int          ch;
    bit          ld;
    bit          en;
    bit          md;
    logic [31:0] dv;
    bit          e_clk;
    bit          e_tick;
    bit          e_pend;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.div  = '0;
    bus.mode = '0;
    bus.load = '0;
    bus.en   = '0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic void add(input bit r, input int ch, input bit ld, input bit en,
                              input bit md, input logic [31:0] dv, input bit ec,
                              input bit et, input bit ep);
    vec_t v;
    v.rst_first = r; v.ch = ch; v.ld = ld; v.en = en; v.md = md; v.dv = dv;
    v.e_clk = ec; v.e_tick = et; v.e_pend = ep;
    vecs.push_back(v);
  endfunction

  task automatic set_ch(input int ch, input bit ld, input bit en, input bit md,
                        input logic [31:0] dv);
    bus.load[ch] = ld;
    bus.en[ch]   = en;
    bus.mode[ch] = md;
    bus.div[ch*CNT_WIDTH +: CNT_WIDTH] = dv;
  endtask

  initial begin
    // Group A: ch0 toggle D=3, loaded while disabled then enabled.
    add(1, 0, 1, 0, 0, 3, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 1, 0);
    // Group B: ch1 strobe D=4.
    add(1, 1, 1, 0, 1, 4, 0, 0, 1);
    add(0, 1, 0, 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1, 1, 0);
    // Group C: ch0 D=9, reload D=2 mid-period, then load D=5 on a wrap edge.
    add(1, 0, 1, 0, 0, 9, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 1, 1, 0, 2, 1, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 2; i++) add(0, 0, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 1, 1, 0, 5, 0, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 1, 0);

    reset = 1'b0;
    do_reset();
    check("reset_clk_out", 32'(bus.clk_out), 0);
    check("reset_tick", 32'(bus.tick), 0);
    check("reset_pending", 32'(bus.pending), 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      set_ch(vecs[i].ch, vecs[i].ld, vecs[i].en, vecs[i].md, vecs[i].dv);
      step();
      bus.load = '0;
      check($sformatf("vec%0d_clk_out", i), 32'(bus.clk_out[vecs[i].ch]), 32'(vecs[i].e_clk));
      check($sformatf("vec%0d_tick", i), 32'(bus.tick[vecs[i].ch]), 32'(vecs[i].e_tick));
      check($sformatf("vec%0d_pending", i), 32'(bus.pending[vecs[i].ch]), 32'(vecs[i].e_pend));
    end

    // Enable freeze on ch2, D=3.
    do_reset();
    set_ch(2, 1, 0, 0, 3);
    step();
    set_ch(2, 0, 1, 0, 3);
    step();
    check("frz_first_tick", 32'(bus.tick[2]), 1);
    step();
    step();
    set_ch(2, 0, 0, 0, 3);
    for (int i = 0; i < 3; i++) begin
      bus.load[2] = (i == 1);
      step();
      check($sformatf("frz%0d_tick", i), 32'(bus.tick[2]), 0);
      check($sformatf("frz%0d_clk_out", i), 32'(bus.clk_out[2]), 1);
    end
    bus.load[2] = 1'b0;
    check("frz_pending_while_off", 32'(bus.pending[2]), 1);
    bus.en[2] = 1'b1;
    step();
    check("frz_resume_no_tick", 32'(bus.tick[2]), 0);
    step();
    check("frz_resume_wrap_tick", 32'(bus.tick[2]), 1);
    check("frz_resume_wrap_clk", 32'(bus.clk_out[2]), 0);
    check("frz_resume_pending", 32'(bus.pending[2]), 0);

    // D=0 toggle on ch3 gives clk/2 with tick held high.
    bus.en[2] = 1'b0;
    set_ch(3, 1, 0, 0, 0);
    step();
    set_ch(3, 0, 1, 0, 0);
    begin
      logic exp_clk;
      exp_clk = 1'b1;
      for (int i = 0; i < 6; i++) begin
        step();
        check($sformatf("d0_%0d_clk_out", i), 32'(bus.clk_out[3]), 32'(exp_clk));
        check($sformatf("d0_%0d_tick", i), 32'(bus.tick[3]), 1);
        exp_clk = ~exp_clk;
      end
    end

    // Asynchronous reset between edges with all channels running.
    do_reset();
    set_ch(0, 1, 0, 0, 9);
    set_ch(1, 1, 0, 0, 2);
    set_ch(2, 1, 0, 1, 5);
    set_ch(3, 1, 0, 0, 0);
    step();
    bus.load = '0;
    bus.en   = '1;
    for (int i = 0; i < 3; i++) step();
    bus.load[0] = 1'b1;
    step();
    bus.load = '0;
    check("arst_pre_pending0", 32'(bus.pending[0]), 1);
    check("arst_pre_tick3", 32'(bus.tick[3]), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_clk_out", 32'(bus.clk_out), 0);
    check("arst_tick", 32'(bus.tick), 0);
    check("arst_pending", 32'(bus.pending), 0);
    #2 reset = 1'b0;
    step();
    check("arst_restart_tick", 32'(bus.tick), 32'hF);
    check("arst_restart_clk1", 32'(bus.clk_out), 32'hF);
    step();
    check("arst_restart_clk2", 32'(bus.clk_out), 32'h0);

    // Independence: four different divisors, ticks counted over 60 cycles.
    do_reset();
    for (int c = 0; c < 4; c++) set_ch(c, 1, 0, 0, 32'(c + 1));
    step();
    bus.load = '0;
    check("ind_pending", 32'(bus.pending), 32'hF);
    bus.en = '1;
    begin
      int cnt[4];
      int exp_cnt[4];
      exp_cnt = '{30, 20, 15, 12};
      cnt = '{0, 0, 0, 0};
      for (int i = 0; i < 60; i++) begin
        step();
        for (int c = 0; c < 4; c++) if (bus.tick[c]) cnt[c]++;
      end
      for (int c = 0; c < 4; c++) check($sformatf("ind_ticks_ch%0d", c), 32'(cnt[c]),
                                         32'(exp_cnt[c]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
